// File: rtl/box_animator_pkg.sv
// rtl/box_animator_pkg.sv - shared constants, state encodings and step helper for the box animator
package box_animator_pkg;

    localparam int COORD_W  = 7;
    localparam int COLOUR_W = 3;
    localparam int STATE_W  = 4;

    localparam int BOX_SIZE        = 4;
    localparam int X_SCREEN_PIXELS = 128;
    localparam int Y_SCREEN_PIXELS = 120;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WAIT_MOVE = 4'd1;
    localparam logic [3:0] S_ERASE_X   = 4'd2;
    localparam logic [3:0] S_ERASE_GX  = 4'd3;
    localparam logic [3:0] S_ERASE_Y   = 4'd4;
    localparam logic [3:0] S_ERASE_W   = 4'd5;
    localparam logic [3:0] S_MOVE      = 4'd6;
    localparam logic [3:0] S_DRAW_X    = 4'd7;
    localparam logic [3:0] S_DRAW_GX   = 4'd8;
    localparam logic [3:0] S_DRAW_Y    = 4'd9;
    localparam logic [3:0] S_DRAW_W    = 4'd10;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    typedef struct packed {
        logic               dir;
        logic [COORD_W-1:0] pos;
    } axis_t;

    // One bounce step on one axis: reflect at 0 and at lim so pos stays in [0,lim].
    function automatic axis_t step_axis(input logic [COORD_W-1:0] pos,
                                        input logic               dir,
                                        input logic [COORD_W-1:0] lim);
        axis_t r;
        r.dir = dir;
        r.pos = pos;
        if (dir == DIR_POS) begin
            if (pos == lim) begin
                r.dir = DIR_NEG;
                r.pos = lim - 1'b1;
            end else begin
                r.pos = pos + 1'b1;
            end
        end else begin
            if (pos == '0) begin
                r.dir = DIR_POS;
                r.pos = COORD_W'(1);
            end else begin
                r.pos = pos - 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/box_animator_frame_pacer.sv
// rtl/box_animator_frame_pacer.sv - tick and frame counters producing a one-cycle move pulse
module box_animator_frame_pacer #(
    parameter int FRAME_TICKS     = 833333,
    parameter int FRAMES_PER_MOVE = 15
) (
    input  logic iClock,
    input  logic iResetn,
    input  logic iEnable,
    output logic oMoveTick
);

    localparam int TICK_W  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int FRAME_W = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;

    logic [TICK_W-1:0]  tick_cnt;
    logic [FRAME_W-1:0] frame_cnt;
    logic               tick_last;
    logic               frame_last;

    assign tick_last  = (tick_cnt == TICK_W'(FRAME_TICKS - 1));
    assign frame_last = (frame_cnt == FRAME_W'(FRAMES_PER_MOVE - 1));

    // Counters advance only while enabled; a frame wrap emits a single-cycle pulse.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            tick_cnt  <= '0;
            frame_cnt <= '0;
            oMoveTick <= 1'b0;
        end else begin
            oMoveTick <= 1'b0;
            if (iEnable) begin
                if (tick_last) begin
                    tick_cnt <= '0;
                    if (frame_last) begin
                        frame_cnt <= '0;
                        oMoveTick <= 1'b1;
                    end else begin
                        frame_cnt <= frame_cnt + FRAME_W'(1);
                    end
                end else begin
                    tick_cnt <= tick_cnt + TICK_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/box_animator.sv
// rtl/box_animator.sv - erase/move/redraw sequencer driving the box drawer strobe protocol
module box_animator
    import box_animator_pkg::*;
#(
    parameter int X_MAX           = 124,
    parameter int Y_MAX           = 116,
    parameter int FRAME_TICKS     = 833333,
    parameter int FRAMES_PER_MOVE = 15,
    parameter int DRAW_WAIT       = 20
) (
    input  logic                iClock,
    input  logic                iResetn,
    input  logic                iEnable,
    input  logic [COLOUR_W-1:0] iColour,
    output logic                oLoadX,
    output logic                oPlotBox,
    output logic [COORD_W-1:0]  oXY_Coord,
    output logic [COLOUR_W-1:0] oColour,
    output logic                oBusy
);

    localparam int WAIT_W = (DRAW_WAIT > 1) ? $clog2(DRAW_WAIT) : 1;

    logic [STATE_W-1:0] state;
    logic [COORD_W-1:0] x_pos;
    logic [COORD_W-1:0] y_pos;
    logic               x_dir;
    logic               y_dir;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               wait_done;
    logic               move_due;
    logic               drawn;
    logic               move_tick;
    axis_t              x_next;
    axis_t              y_next;

    assign wait_done = (wait_cnt == WAIT_W'(DRAW_WAIT - 1));
    assign x_next    = step_axis(x_pos, x_dir, COORD_W'(X_MAX));
    assign y_next    = step_axis(y_pos, y_dir, COORD_W'(Y_MAX));

    box_animator_frame_pacer #(
        .FRAME_TICKS    (FRAME_TICKS),
        .FRAMES_PER_MOVE(FRAMES_PER_MOVE)
    ) u_pacer (
        .iClock   (iClock),
        .iResetn  (iResetn),
        .iEnable  (iEnable),
        .oMoveTick(move_tick)
    );

    // Pending-move flag: saturates on repeated frame wraps; a new wrap beats the clear.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            move_due <= 1'b0;
        end else if (move_tick) begin
            move_due <= 1'b1;
        end else if (state == S_WAIT_MOVE && iEnable && move_due) begin
            move_due <= 1'b0;
        end
    end

    // Sequencer: erase at old position, step, redraw; sequences always run to completion.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state    <= S_IDLE;
            x_pos    <= '0;
            y_pos    <= '0;
            x_dir    <= DIR_POS;
            y_dir    <= DIR_POS;
            wait_cnt <= '0;
            drawn    <= 1'b0;
        end else begin
            case (state)
                S_IDLE:      if (iEnable) state <= drawn ? S_WAIT_MOVE : S_DRAW_X;
                S_WAIT_MOVE: begin
                    if (!iEnable)     state <= S_IDLE;
                    else if (move_due) state <= S_ERASE_X;
                end
                S_ERASE_X:   state <= S_ERASE_GX;
                S_ERASE_GX:  state <= S_ERASE_Y;
                S_ERASE_Y: begin
                    wait_cnt <= '0;
                    state    <= S_ERASE_W;
                end
                S_ERASE_W: begin
                    if (wait_done) begin
                        wait_cnt <= '0;
                        state    <= S_MOVE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_MOVE: begin
                    x_pos <= x_next.pos;
                    x_dir <= x_next.dir;
                    y_pos <= y_next.pos;
                    y_dir <= y_next.dir;
                    state <= S_DRAW_X;
                end
                S_DRAW_X:    state <= S_DRAW_GX;
                S_DRAW_GX:   state <= S_DRAW_Y;
                S_DRAW_Y: begin
                    wait_cnt <= '0;
                    state    <= S_DRAW_W;
                end
                S_DRAW_W: begin
                    if (wait_done) begin
                        wait_cnt <= '0;
                        drawn    <= 1'b1;
                        state    <= iEnable ? S_WAIT_MOVE : S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default:     state <= S_IDLE;
            endcase
        end
    end

    // Moore decode of drawer strobes, coordinate mux and colour (black while erasing).
    always_comb begin
        oLoadX    = (state == S_ERASE_X) || (state == S_DRAW_X);
        oPlotBox  = (state == S_ERASE_Y) || (state == S_DRAW_Y);
        oXY_Coord = '0;
        if (oLoadX)        oXY_Coord = x_pos;
        else if (oPlotBox) oXY_Coord = y_pos;
        oColour   = (state == S_DRAW_Y) ? iColour : '0;
        oBusy     = (state != S_IDLE) && (state != S_WAIT_MOVE);
    end

endmodule
